// File: rtl/address_sequencer_pkg.sv
// Shared encodings for the address sequencer: command opcodes, ARF function and
// register-select codes, output-select codes and the controller state set.
package address_sequencer_pkg;

    typedef enum logic [2:0] {
        OpNop   = 3'b000,
        OpFetch = 3'b001,
        OpPush  = 3'b010,
        OpPop   = 3'b011,
        OpCall  = 3'b100,
        OpRet   = 3'b101,
        OpLdar  = 3'b110,
        OpIncar = 3'b111
    } cmd_op_e;

    localparam logic [2:0] FUN_DEC   = 3'b000;
    localparam logic [2:0] FUN_INC   = 3'b001;
    localparam logic [2:0] FUN_LOAD  = 3'b010;
    localparam logic [2:0] FUN_CLEAR = 3'b011;

    // Active-low enables ordered {PC, AR, SP}
    localparam logic [2:0] SEL_PC   = 3'b011;
    localparam logic [2:0] SEL_AR   = 3'b101;
    localparam logic [2:0] SEL_SP   = 3'b110;
    localparam logic [2:0] SEL_NONE = 3'b111;

    localparam logic [1:0] OUT_PC = 2'b00;
    localparam logic [1:0] OUT_AR = 2'b10;
    localparam logic [1:0] OUT_SP = 2'b11;

    typedef enum logic [3:0] {
        StInitPc,
        StInitSp,
        StIdle,
        StFetchLo,
        StFetchHi,
        StPushHi,
        StPushLo,
        StPop1,
        StPop2,
        StPop3,
        StLoadPc,
        StSingle
    } state_e;

    function automatic state_e first_state(input cmd_op_e op);
        case (op)
            OpFetch:        return StFetchLo;
            OpPush, OpCall: return StPushHi;
            OpPop, OpRet:   return StPop1;
            default:        return StSingle;
        endcase
    endfunction

endpackage

// File: rtl/address_sequencer.sv
// Multi-cycle controller sequencing the PC/AR/SP register file and byte-wide memory
// for fetch, push/pop, call/return and AR updates.
module address_sequencer
    import address_sequencer_pkg::*;
#(
    parameter logic [15:0] SP_INIT  = 16'hFFFE,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_data,
    input  logic [15:0] PcIn,
    input  logic [7:0]  MemRData,
    output logic [2:0]  FunSel,
    output logic [2:0]  RegSel,
    output logic [1:0]  OutCSel,
    output logic [1:0]  OutDSel,
    output logic [15:0] ArfI,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [7:0]  MemWData,
    output logic        IRLoadLo,
    output logic        IRLoadHi,
    output logic [15:0] PopData,
    output logic        done,
    output logic        busy
);

    state_e      state_q, state_d;
    cmd_op_e     op_q, op_d;
    logic [15:0] data_q, data_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] pop_q, pop_d;
    logic [15:0] push_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInitPc;
            op_q    <= OpNop;
            data_q  <= '0;
            pc_q    <= '0;
            lo_q    <= '0;
            pop_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
            lo_q    <= lo_d;
            pop_q   <= pop_d;
        end
    end

    // CALL pushes the return address captured at accept instead of the command data
    assign push_word = (op_q == OpCall) ? pc_q : data_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        pc_d      = pc_q;
        lo_d      = lo_q;
        pop_d     = pop_q;
        FunSel    = FUN_DEC;
        RegSel    = SEL_NONE;
        OutCSel   = OUT_PC;
        OutDSel   = OUT_AR;
        ArfI      = '0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemWData  = '0;
        IRLoadLo  = 1'b0;
        IRLoadHi  = 1'b0;
        done      = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b1;

        unique case (state_q)
            StInitPc: begin
                RegSel  = SEL_PC;
                FunSel  = (RESET_PC == 16'h0000) ? FUN_CLEAR : FUN_LOAD;
                ArfI    = RESET_PC;
                state_d = StInitSp;
            end
            StInitSp: begin
                RegSel  = SEL_SP;
                FunSel  = FUN_LOAD;
                ArfI    = SP_INIT;
                state_d = StIdle;
            end
            StIdle: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = cmd_op_e'(cmd_op);
                    data_d  = cmd_data;
                    pc_d    = PcIn;
                    state_d = first_state(cmd_op_e'(cmd_op));
                end
            end
            StFetchLo, StFetchHi: begin
                OutDSel = OUT_PC;
                MemRead = 1'b1;
                FunSel  = FUN_INC;
                RegSel  = SEL_PC;
                if (state_q == StFetchLo) begin
                    IRLoadLo = 1'b1;
                    state_d  = StFetchHi;
                end else begin
                    IRLoadHi = 1'b1;
                    done     = 1'b1;
                    state_d  = StIdle;
                end
            end
            StPushHi: begin
                OutDSel  = OUT_SP;
                MemWrite = 1'b1;
                MemWData = push_word[15:8];
                FunSel   = FUN_DEC;
                RegSel   = SEL_SP;
                state_d  = StPushLo;
            end
            StPushLo: begin
                OutDSel  = OUT_SP;
                MemWrite = 1'b1;
                MemWData = push_word[7:0];
                FunSel   = FUN_DEC;
                RegSel   = SEL_SP;
                if (op_q == OpCall) begin
                    state_d = StLoadPc;
                end else begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            StLoadPc: begin
                ArfI    = data_q;
                FunSel  = FUN_LOAD;
                RegSel  = SEL_PC;
                done    = 1'b1;
                state_d = StIdle;
            end
            StPop1: begin
                FunSel  = FUN_INC;
                RegSel  = SEL_SP;
                state_d = StPop2;
            end
            StPop2: begin
                OutDSel = OUT_SP;
                MemRead = 1'b1;
                lo_d    = MemRData;
                FunSel  = FUN_INC;
                RegSel  = SEL_SP;
                state_d = StPop3;
            end
            StPop3: begin
                OutDSel = OUT_SP;
                MemRead = 1'b1;
                pop_d   = {MemRData, lo_q};
                done    = 1'b1;
                if (op_q == OpRet) begin
                    ArfI   = {MemRData, lo_q};
                    FunSel = FUN_LOAD;
                    RegSel = SEL_PC;
                end
                state_d = StIdle;
            end
            StSingle: begin
                done = 1'b1;
                if (op_q == OpLdar) begin
                    ArfI   = data_q;
                    FunSel = FUN_LOAD;
                    RegSel = SEL_AR;
                end else if (op_q == OpIncar) begin
                    FunSel = FUN_INC;
                    RegSel = SEL_AR;
                end
                state_d = StIdle;
            end
            default: state_d = StInitPc;
        endcase

        // While reset is held the file must be left untouched, even though state is INIT_PC
        if (!rst_n) begin
            FunSel    = FUN_DEC;
            RegSel    = SEL_NONE;
            ArfI      = '0;
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            MemWData  = '0;
            IRLoadLo  = 1'b0;
            IRLoadHi  = 1'b0;
            done      = 1'b0;
            cmd_ready = 1'b0;
        end
    end

    assign PopData = (state_q == StPop3) ? pop_d : pop_q;

endmodule

// File: tb/tb_address_sequencer.sv
// Directed bench for address_sequencer with a behavioural ARF and byte memory around it.
module tb_address_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [15:0] PcIn;
    logic [7:0]  MemRData;
    logic [2:0]  FunSel;
    logic [2:0]  RegSel;
    logic [1:0]  OutCSel;
    logic [1:0]  OutDSel;
    logic [15:0] ArfI;
    logic        MemRead;
    logic        MemWrite;
    logic [7:0]  MemWData;
    logic        IRLoadLo;
    logic        IRLoadHi;
    logic [15:0] PopData;
    logic        done;
    logic        busy;

    address_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .PcIn     (PcIn),
        .MemRData (MemRData),
        .FunSel   (FunSel),
        .RegSel   (RegSel),
        .OutCSel  (OutCSel),
        .OutDSel  (OutDSel),
        .ArfI     (ArfI),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .MemWData (MemWData),
        .IRLoadLo (IRLoadLo),
        .IRLoadHi (IRLoadHi),
        .PopData  (PopData),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Behavioural register file and memory; the bench alters them only via poke requests
    logic [15:0] m_pc, m_ar, m_sp;
    logic [7:0]  mem [0:65535];
    logic [15:0] maddr;
    logic        poke_en = 1'b0;
    int          poke_kind = 0;
    logic [15:0] poke_addr = '0;
    logic [15:0] poke_val = '0;

    function automatic logic [15:0] arf_next(input logic [15:0] v);
        case (FunSel)
            3'b000:  return v - 16'd1;
            3'b001:  return v + 16'd1;
            3'b010:  return ArfI;
            3'b011:  return 16'h0000;
            default: return v;
        endcase
    endfunction

    always_comb begin
        case (OutDSel)
            2'b10:   maddr = m_ar;
            2'b11:   maddr = m_sp;
            default: maddr = m_pc;
        endcase
        case (OutCSel)
            2'b10:   PcIn = m_ar;
            2'b11:   PcIn = m_sp;
            default: PcIn = m_pc;
        endcase
    end
    assign MemRData = mem[maddr];

    always @(posedge clk) begin
        if (MemWrite) mem[maddr] <= MemWData;
        if (!RegSel[2]) m_pc <= arf_next(m_pc);
        if (!RegSel[1]) m_ar <= arf_next(m_ar);
        if (!RegSel[0]) m_sp <= arf_next(m_sp);
        if (poke_en) begin
            case (poke_kind)
                0:       m_pc <= poke_val;
                1:       m_sp <= poke_val;
                default: mem[poke_addr] <= poke_val[7:0];
            endcase
        end
    end

    int done_cnt = 0;
    int viol = 0;
    int rst_strobes = 0;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (MemRead && MemWrite) viol++;
        if ($countones(~RegSel) > 1) viol++;
        if (!rst_n && (MemRead || MemWrite || done || IRLoadLo || IRLoadHi)) rst_strobes++;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int kind, input logic [15:0] a, input logic [15:0] v);
        poke_kind = kind;
        poke_addr = a;
        poke_val  = v;
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    int          last_cycles, lo_cyc, hi_cyc;
    logic [7:0]  lo_byte, hi_byte;
    logic [15:0] last_pop;

    // Present one command at a negedge and sample every execution cycle until done
    task automatic start_cmd(input logic [2:0] op, input logic [15:0] data);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_data  = '0;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [15:0] data);
        last_cycles = 0;
        lo_cyc      = 0;
        hi_cyc      = 0;
        lo_byte     = 'x;
        hi_byte     = 'x;
        last_pop    = 'x;
        start_cmd(op, data);
        for (int c = 1; c <= 8; c++) begin
            if (IRLoadLo) begin lo_byte = MemRData; lo_cyc = c; end
            if (IRLoadHi) begin hi_byte = MemRData; hi_cyc = c; end
            if (done) begin
                last_cycles = c;
                last_pop    = PopData;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        check("ready_after_done", {31'd0, cmd_ready}, 32'd1);
    endtask

    int saved_done;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_regsel", {29'd0, RegSel}, 32'h7);
        check("rst_done", {31'd0, done}, 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check("init_sp_ready", {31'd0, cmd_ready}, 32'd0);
        check("init_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("idle_ready", {31'd0, cmd_ready}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("init_pc", {16'd0, m_pc}, 32'h0000);
        check("init_sp", {16'd0, m_sp}, 32'hFFFE);
        check("idle_outdsel", {30'd0, OutDSel}, 32'h2);

        // FETCH
        poke(0, 16'h0000, 16'h0010);
        poke(2, 16'h0010, 16'h0034);
        poke(2, 16'h0011, 16'h0012);
        run_cmd(3'b001, 16'h0000);
        check("fetch_cycles", last_cycles, 32'd2);
        check("fetch_lo_cyc", lo_cyc, 32'd1);
        check("fetch_lo_byte", {24'd0, lo_byte}, 32'h34);
        check("fetch_hi_cyc", hi_cyc, 32'd2);
        check("fetch_hi_byte", {24'd0, hi_byte}, 32'h12);
        check("fetch_pc", {16'd0, m_pc}, 32'h0012);

        // PUSH then POP
        run_cmd(3'b010, 16'hBEEF);
        check("push_cycles", last_cycles, 32'd2);
        check("push_mem_fffe", {24'd0, mem[16'hFFFE]}, 32'hBE);
        check("push_mem_fffd", {24'd0, mem[16'hFFFD]}, 32'hEF);
        check("push_sp", {16'd0, m_sp}, 32'hFFFC);
        run_cmd(3'b011, 16'h0000);
        check("pop_cycles", last_cycles, 32'd3);
        check("pop_data", {16'd0, last_pop}, 32'hBEEF);
        check("pop_sp", {16'd0, m_sp}, 32'hFFFE);
        check("pop_data_held", {16'd0, PopData}, 32'hBEEF);

        // CALL then RET
        poke(0, 16'h0000, 16'h0123);
        run_cmd(3'b100, 16'h0400);
        check("call_cycles", last_cycles, 32'd3);
        check("call_mem_fffe", {24'd0, mem[16'hFFFE]}, 32'h01);
        check("call_mem_fffd", {24'd0, mem[16'hFFFD]}, 32'h23);
        check("call_pc", {16'd0, m_pc}, 32'h0400);
        check("call_sp", {16'd0, m_sp}, 32'hFFFC);
        run_cmd(3'b101, 16'h0000);
        check("ret_cycles", last_cycles, 32'd3);
        check("ret_pc", {16'd0, m_pc}, 32'h0123);
        check("ret_sp", {16'd0, m_sp}, 32'hFFFE);
        check("ret_popdata", {16'd0, PopData}, 32'h0123);

        // AR updates and NOP
        run_cmd(3'b110, 16'h8000);
        check("ldar_cycles", last_cycles, 32'd1);
        check("ldar_ar", {16'd0, m_ar}, 32'h8000);
        run_cmd(3'b111, 16'h0000);
        check("incar1_cycles", last_cycles, 32'd1);
        run_cmd(3'b111, 16'h0000);
        check("incar2_cycles", last_cycles, 32'd1);
        check("incar_ar", {16'd0, m_ar}, 32'h8002);
        run_cmd(3'b000, 16'h0000);
        check("nop_cycles", last_cycles, 32'd1);
        check("nop_pc", {16'd0, m_pc}, 32'h0123);

        // SP wraps 0000 -> FFFF during PUSH
        poke(1, 16'h0000, 16'h0000);
        run_cmd(3'b010, 16'h1234);
        check("wrap_mem_0000", {24'd0, mem[16'h0000]}, 32'h12);
        check("wrap_mem_ffff", {24'd0, mem[16'hFFFF]}, 32'h34);
        check("wrap_sp", {16'd0, m_sp}, 32'hFFFE);

        // Reset during POP Q2
        saved_done = done_cnt;
        start_cmd(3'b011, 16'h0000);
        @(negedge clk);
        check("q2_memread", {31'd0, MemRead}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_memread", {31'd0, MemRead}, 32'd0);
        check("midrst_regsel", {29'd0, RegSel}, 32'h7);
        check("midrst_popdata", {16'd0, PopData}, 32'h0000);
        repeat (2) @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("reinit_not_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("reinit_ready", {31'd0, cmd_ready}, 32'd1);
        check("reinit_pc", {16'd0, m_pc}, 32'h0000);
        check("reinit_sp", {16'd0, m_sp}, 32'hFFFE);
        check("midrst_no_done", done_cnt, saved_done);
        check("rst_no_strobes", rst_strobes, 32'd0);
        check("invariants", viol, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
